mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Bridges the M stage of the pipeline to a split address/data memory bus.
//   It accepts one load or store at a time and latches the address, byte
//   enables, store data and byte offset when it accepts the op. It then runs
//   a single bus transaction, capturing the returned word for loads.
//   Pipeline flushes either cancel the op before the address phase or drain
//   the outstanding response. It tells the pipeline to stall while the op is
//   in flight, and it pulses m_done on completion.
//
// Optional feature:
//   MEM_ACCESS_CTRL_ALIGN_CHECK_EN - when defined, a misaligned normal
//   half/word access is rejected in IDLE. The controller then pulses
//   m_adel (load) or m_ades (store) instead of issuing to the bus. When the
//   macro is undefined, misaligned ops are issued with their shifted enables
//   and m_adel/m_ades are tied low.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   m_req, m_write      M-stage op present / 1 = store
//   m_size, m_part      0 byte, 1 half, 2 word / 00 normal, 01 left, 10 right
//   m_addr, m_wdata     byte address / unaligned register store value
//   flush               cancels the M-stage op
//   m_stall, m_done     pipeline hold / one-cycle completion pulse
//   m_rdata, m_offset   raw captured bus word / latched m_addr[1:0]
//   m_adel, m_ades      load/store address-error pulse
//   bus_req, bus_wr     request valid / write
//   bus_addr, bus_be    word-aligned address / byte enables
//   bus_wdata           lane-aligned store data
//   bus_addr_ok         address phase accepted
//   bus_data_ok         read data valid / write acknowledge
//   bus_rdata           read data
//
// States:
//   IDLE  | no op in flight; accepts a new request
//   REQ   | bus_req high, waiting for bus_addr_ok
//   WAIT  | address accepted, waiting for bus_data_ok
//   DONE  | op complete, m_done pulses (unless flushed)
//   DRAIN | flushed after address phase; discards the pending response
// -----------------------------------------------------------------------------
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_write,
  input  logic [1:0]  m_size,
  input  logic [1:0]  m_part,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        flush,
  output logic        m_stall,
  output logic        m_done,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_offset,
  output logic        m_adel,
  output logic        m_ades,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;

  logic [31:0] addr_q;
  logic        wr_q;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  offset_q;
  logic [31:0] rdata_q;

  logic [1:0]  off;
  logic        err;
  logic        in_idle_req;
  logic        accept;
  logic        capture;

  assign off         = m_addr[1:0];
  assign in_idle_req = (state_q == ST_IDLE) && m_req && !flush && !reset;

`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
  // Only normal accesses are alignment-checked; lwl/lwr/swl/swr exist
  // precisely to handle unaligned words. Size 3 is treated as a word.
  assign err    = (m_part == 2'b00) &&
                  (((m_size == 2'd1) && m_addr[0]) ||
                   (m_size[1] && (m_addr[1:0] != 2'b00)));
  assign m_adel = in_idle_req && err && !m_write;
  assign m_ades = in_idle_req && err &&  m_write;
`else
  assign err    = 1'b0;
  assign m_adel = 1'b0;
  assign m_ades = 1'b0;
`endif

  assign accept = in_idle_req && !err;

  // Loads capture only on the response that completes the op. A flush in REQ
  // that coincides with the full handshake drops the data.
  assign capture = !wr_q && bus_data_ok &&
                   ((state_q == ST_WAIT) ||
                    ((state_q == ST_REQ) && bus_addr_ok && !flush));

  // Byte-lane steering for the op being accepted.
  always_comb begin
    be_d    = 4'hF;
    wdata_d = m_wdata;
    if (m_write) begin
      case (m_part)
        2'b01: begin
          be_d    = 4'hF >> (2'd3 - off);
          wdata_d = m_wdata >> {(2'd3 - off), 3'b000};
        end
        2'b10: begin
          be_d    = 4'hF << off;
          wdata_d = m_wdata << {off, 3'b000};
        end
        default: begin
          case (m_size)
            2'd0: begin
              be_d    = 4'b0001 << off;
              wdata_d = {4{m_wdata[7:0]}};
            end
            2'd1: begin
              be_d    = 4'b0011 << off;
              wdata_d = {2{m_wdata[15:0]}};
            end
            default: begin
              be_d    = 4'hF;
              wdata_d = m_wdata;
            end
          endcase
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus_addr_ok) begin
          if (flush && bus_data_ok) state_d = ST_IDLE;
          else if (flush)           state_d = ST_DRAIN;
          else if (bus_data_ok)     state_d = ST_DONE;
          else                      state_d = ST_WAIT;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) state_d = ST_DONE;
        else if (flush)  state_d = ST_DRAIN;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus_data_ok) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    m_stall = 1'b0;
    m_done  = 1'b0;
    bus_req = 1'b0;
    case (state_q)
      ST_IDLE:  m_stall = accept;
      ST_REQ: begin
        m_stall = 1'b1;
        bus_req = 1'b1;
      end
      ST_WAIT:  m_stall = 1'b1;
      ST_DONE:  m_done  = !flush;
      ST_DRAIN: m_stall = m_req;
      default: begin
        m_stall = 1'b0;
      end
    endcase
  end

  // Latched op and captured read data; the bus is driven only from these.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= 32'h0;
      wr_q     <= 1'b0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      offset_q <= 2'b00;
      rdata_q  <= 32'h0;
    end else begin
      if (accept) begin
        addr_q   <= {m_addr[31:2], 2'b00};
        wr_q     <= m_write;
        be_q     <= be_d;
        wdata_q  <= wdata_d;
        offset_q <= off;
      end
      if (capture) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  assign bus_wr    = wr_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign m_rdata   = rdata_q;
  assign m_offset  = offset_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [1:0]  m_part;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        flush;
  logic        m_stall;
  logic        m_done;
  logic [31:0] m_rdata;
  logic [1:0]  m_offset;
  logic        m_adel;
  logic        m_ades;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .m_req       (m_req),
    .m_write     (m_write),
    .m_size      (m_size),
    .m_part      (m_part),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .flush       (flush),
    .m_stall     (m_stall),
    .m_done      (m_done),
    .m_rdata     (m_rdata),
    .m_offset    (m_offset),
    .m_adel      (m_adel),
    .m_ades      (m_ades),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic w, input logic [1:0] sz, input logic [1:0] pt,
                        input logic [31:0] a, input logic [31:0] d);
    m_req   = 1'b1;
    m_write = w;
    m_size  = sz;
    m_part  = pt;
    m_addr  = a;
    m_wdata = d;
  endtask

  // Op completed with addr_ok and data_ok in the first REQ cycle.
  task automatic run_imm(input string tag, input logic w, input logic [1:0] sz,
                         input logic [1:0] pt, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_off);
    tick();
    set_op(w, sz, pt, a, d);
    settle();
    chk({tag, "/accept_stall"}, m_stall, 1'b1);
    tick();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = rd;
    settle();
    chk({tag, "/bus_req"}, bus_req, 1'b1);
    chk({tag, "/bus_addr"}, bus_addr, exp_addr);
    chk({tag, "/bus_be"}, bus_be, exp_be);
    chk({tag, "/bus_wdata"}, bus_wdata, exp_wd);
    chk({tag, "/bus_wr"}, bus_wr, w);
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    m_req       = 1'b0;
    settle();
    chk({tag, "/done"}, m_done, 1'b1);
    chk({tag, "/done_stall"}, m_stall, 1'b0);
    chk({tag, "/m_rdata"}, m_rdata, exp_rdata);
    chk({tag, "/m_offset"}, m_offset, exp_off);
    tick();
    settle();
    chk({tag, "/done_cleared"}, m_done, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/m_stall"}, m_stall, 1'b0);
    chk({tag, "/m_done"}, m_done, 1'b0);
    chk({tag, "/m_adel"}, m_adel, 1'b0);
    chk({tag, "/m_ades"}, m_ades, 1'b0);
    chk({tag, "/bus_req"}, bus_req, 1'b0);
    chk({tag, "/bus_wr"}, bus_wr, 1'b0);
    chk({tag, "/bus_be"}, bus_be, 4'h0);
    chk({tag, "/bus_addr"}, bus_addr, 32'h0);
    chk({tag, "/bus_wdata"}, bus_wdata, 32'h0);
    chk({tag, "/m_rdata"}, m_rdata, 32'h0);
    chk({tag, "/m_offset"}, m_offset, 2'b00);
  endtask

  initial begin
    reset       = 1'b1;
    m_req       = 1'b0;
    m_write     = 1'b0;
    m_size      = 2'd0;
    m_part      = 2'b00;
    m_addr      = 32'h0;
    m_wdata     = 32'h0;
    flush       = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;

    // Reset overrides a pending request.
    tick();
    set_op(1'b0, 2'd2, 2'b00, 32'h0000_1000, 32'h0);
    settle();
    chk("rst_hold_stall", m_stall, 1'b0);
    tick();
    tick();
    settle();
    chk_reset_vals("rst");
    m_req = 1'b0;
    reset = 1'b0;

    // Load word 0x1000: addr_ok in cycle 2, data_ok in cycle 4.
    tick();
    set_op(1'b0, 2'd2, 2'b00, 32'h0000_1000, 32'h0);
    settle();
    chk("lw/c0_stall", m_stall, 1'b1);
    chk("lw/c0_bus_req", bus_req, 1'b0);
    tick();
    settle();
    chk("lw/c1_stall", m_stall, 1'b1);
    chk("lw/c1_bus_req", bus_req, 1'b1);
    chk("lw/c1_bus_addr", bus_addr, 32'h0000_1000);
    chk("lw/c1_bus_be", bus_be, 4'hF);
    chk("lw/c1_bus_wr", bus_wr, 1'b0);
    tick();
    bus_addr_ok = 1'b1;
    settle();
    chk("lw/c2_stall", m_stall, 1'b1);
    chk("lw/c2_bus_req", bus_req, 1'b1);
    tick();
    bus_addr_ok = 1'b0;
    settle();
    chk("lw/c3_stall", m_stall, 1'b1);
    chk("lw/c3_bus_req", bus_req, 1'b0);
    tick();
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hDEAD_BEEF;
    settle();
    chk("lw/c4_done", m_done, 1'b0);
    tick();
    bus_data_ok = 1'b0;
    m_req       = 1'b0;
    settle();
    chk("lw/c5_done", m_done, 1'b1);
    chk("lw/c5_stall", m_stall, 1'b0);
    chk("lw/c5_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("lw/c5_offset", m_offset, 2'd0);
    tick();
    settle();
    chk("lw/c6_done", m_done, 1'b0);

    // Stores complete in one bus cycle; m_rdata must keep the last load.
    run_imm("sb", 1'b1, 2'd0, 2'b00, 32'h0000_2003, 32'h0000_00A5, 32'h1234_5678,
            32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 2'd3);
    run_imm("swl", 1'b1, 2'd2, 2'b01, 32'h0000_3001, 32'h1122_3344, 32'h1234_5678,
            32'h0000_3000, 4'b0011, 32'h0000_1122, 32'hDEAD_BEEF, 2'd1);
    run_imm("swr", 1'b1, 2'd2, 2'b10, 32'h0000_3001, 32'h1122_3344, 32'h1234_5678,
            32'h0000_3000, 4'b1110, 32'h2233_4400, 32'hDEAD_BEEF, 2'd1);
    run_imm("sh", 1'b1, 2'd1, 2'b00, 32'h0000_2002, 32'hAABB_CCDD, 32'h1234_5678,
            32'h0000_2000, 4'b1100, 32'hCCDD_CCDD, 32'hDEAD_BEEF, 2'd2);
    run_imm("lb", 1'b0, 2'd0, 2'b00, 32'h0000_5001, 32'h0, 32'hCAFE_F00D,
            32'h0000_5000, 4'hF, 32'h0, 32'hCAFE_F00D, 2'd1);

    // Flush in WAIT; response arrives three cycles later and is discarded.
    tick();
    set_op(1'b0, 2'd2, 2'b00, 32'h0000_6000, 32'h0);
    settle();
    chk("drain/c0_stall", m_stall, 1'b1);
    tick();
    bus_addr_ok = 1'b1;
    settle();
    chk("drain/c1_bus_req", bus_req, 1'b1);
    tick();
    bus_addr_ok = 1'b0;
    flush       = 1'b1;
    settle();
    chk("drain/c2_wait_stall", m_stall, 1'b1);
    chk("drain/c2_done", m_done, 1'b0);
    tick();
    flush = 1'b0;
    m_req = 1'b0;
    settle();
    chk("drain/c3_stall", m_stall, 1'b0);
    chk("drain/c3_done", m_done, 1'b0);
    chk("drain/c3_bus_req", bus_req, 1'b0);
    tick();
    m_req = 1'b1;
    settle();
    chk("drain/c4_newreq_stall", m_stall, 1'b1);
    chk("drain/c4_bus_req", bus_req, 1'b0);
    tick();
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hBADB_AD00;
    settle();
    chk("drain/c5_stall", m_stall, 1'b1);
    chk("drain/c5_done", m_done, 1'b0);
    tick();
    bus_data_ok = 1'b0;
    m_req       = 1'b0;
    settle();
    chk("drain/c6_done", m_done, 1'b0);
    chk("drain/c6_stall", m_stall, 1'b0);
    chk("drain/c6_bus_req", bus_req, 1'b0);
    chk("drain/c6_rdata", m_rdata, 32'hCAFE_F00D);
    tick();
    settle();
    chk("drain/c7_bus_req", bus_req, 1'b0);

    // Flush in REQ before addr_ok: dropped with no bus transaction.
    tick();
    set_op(1'b1, 2'd2, 2'b00, 32'h0000_8000, 32'h0000_0055);
    settle();
    tick();
    flush = 1'b1;
    m_req = 1'b0;
    settle();
    chk("flreq/c1_bus_req", bus_req, 1'b1);
    tick();
    flush = 1'b0;
    settle();
    chk("flreq/c2_bus_req", bus_req, 1'b0);
    chk("flreq/c2_stall", m_stall, 1'b0);
    tick();
    bus_data_ok = 1'b1;
    settle();
    tick();
    bus_data_ok = 1'b0;
    settle();
    chk("flreq/stray_done", m_done, 1'b0);

    // Misaligned normal word load at 0x4002.
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
    tick();
    set_op(1'b0, 2'd2, 2'b00, 32'h0000_4002, 32'h0);
    settle();
    chk("adel/pulse", m_adel, 1'b1);
    chk("adel/ades", m_ades, 1'b0);
    chk("adel/stall", m_stall, 1'b0);
    tick();
    m_req = 1'b0;
    settle();
    chk("adel/cleared", m_adel, 1'b0);
    chk("adel/bus_req", bus_req, 1'b0);
    tick();
    set_op(1'b1, 2'd1, 2'b00, 32'h0000_4001, 32'h0);
    settle();
    chk("ades/pulse", m_ades, 1'b1);
    chk("ades/adel", m_adel, 1'b0);
    tick();
    m_req = 1'b0;
    settle();
    chk("ades/bus_req", bus_req, 1'b0);
`else
    run_imm("lw_unal", 1'b0, 2'd2, 2'b00, 32'h0000_4002, 32'h0, 32'h0BAD_F00D,
            32'h0000_4000, 4'hF, 32'h0, 32'h0BAD_F00D, 2'd2);
    chk("lw_unal/adel", m_adel, 1'b0);
`endif

    // Reset while in REQ abandons the op; a later data_ok is ignored.
    tick();
    set_op(1'b1, 2'd0, 2'b00, 32'h0000_7005, 32'h0000_0077);
    settle();
    tick();
    m_req = 1'b0;
    reset = 1'b1;
    settle();
    chk("rstreq/c1_bus_req", bus_req, 1'b1);
    tick();
    reset = 1'b0;
    settle();
    chk_reset_vals("rstreq");
    tick();
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h9999_9999;
    settle();
    tick();
    bus_data_ok = 1'b0;
    settle();
    chk("rstreq/late_done", m_done, 1'b0);
    chk("rstreq/late_rdata", m_rdata, 32'h0);
    chk("rstreq/late_bus_req", bus_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
